// File: rtl/stopwatch_display_spi.sv
// Streams the stopwatch's eight BCD digits to a MAX7219-style driver over 3-wire SPI.
// Optional decimal points per digit when STOPWATCH_DP_EN is defined (adds dp_in).
module stopwatch_display_spi #(
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [3:0]  INTENSITY = 4'h8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits_in,
`ifdef STOPWATCH_DP_EN
  input  logic [7:0]  dp_in,
`endif
  input  logic        update,
  output logic        busy,
  output logic        init_done,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi
);

  localparam logic [1:0] S_INIT    = 2'd0;
  localparam logic [1:0] S_REFRESH = 2'd1;
  localparam logic [1:0] S_IDLE    = 2'd2;
  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [5:0] SLOT_GAP  = 6'd33;

  logic [1:0]  r_state;
  logic        r_in_frame;
  logic [5:0]  r_slot;
  logic [7:0]  r_div;
  logic [2:0]  r_idx;
  logic        r_pending;
  logic        r_init_done;
  logic [31:0] r_shadow;

  logic        w_last_div;
  logic        w_frame_end;
  logic        w_seq_last;
  logic        w_want_refresh;
  logic        w_load_shadow;
  logic        w_in_bits;
  logic        w_dp_bit;
  logic [3:0]  w_nibble;
  logic [7:0]  w_addr;
  logic [15:0] w_frame;

  // A frame is 34 slots of CLK_DIV cycles: 32 bit half-periods, a CS hold slot, a CS-high gap.
  assign w_last_div     = (r_div == DIV_LAST);
  assign w_frame_end    = r_in_frame && w_last_div && (r_slot == SLOT_GAP);
  assign w_seq_last     = (r_state == S_INIT) ? (r_idx == 3'd4) : (r_idx == 3'd7);
  assign w_want_refresh = r_pending | update;
  assign w_load_shadow  = ((r_state == S_IDLE) && update) ||
                          (w_frame_end && w_seq_last && w_want_refresh);

`ifdef STOPWATCH_DP_EN
  logic [7:0] r_dp;
  assign w_dp_bit = r_dp[r_idx];
`else
  assign w_dp_bit = 1'b0;
`endif

  assign w_nibble = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_addr   = 8'({5'b00000, r_idx}) + 8'd1;

  always_comb begin
    w_frame = {w_addr, w_dp_bit, 3'b000, w_nibble};
    if (r_state == S_INIT) begin
      case (r_idx)
        3'd0:    w_frame = 16'h09FF;
        3'd1:    w_frame = {8'h0A, 4'h0, INTENSITY};
        3'd2:    w_frame = 16'h0B07;
        3'd3:    w_frame = 16'h0C01;
        default: w_frame = 16'h0F00;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign init_done = r_init_done;
  assign w_in_bits = r_in_frame && !r_slot[5];
  assign spi_cs_n  = !(r_in_frame && (r_slot != SLOT_GAP));
  assign spi_sclk  = w_in_bits && r_slot[0];
  assign spi_mosi  = w_in_bits && w_frame[~r_slot[4:1]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_INIT;
      r_in_frame  <= 1'b0;
      r_slot      <= '0;
      r_div       <= '0;
      r_idx       <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (update) begin
            r_state    <= S_REFRESH;
            r_in_frame <= 1'b1;
            r_slot     <= '0;
            r_div      <= '0;
            r_idx      <= '0;
          end
        end
        default: begin
          if (!r_in_frame) begin
            r_in_frame <= 1'b1;
            r_slot     <= '0;
            r_div      <= '0;
            r_idx      <= '0;
          end else if (w_frame_end) begin
            r_slot <= '0;
            r_div  <= '0;
            if (!w_seq_last) begin
              r_idx <= r_idx + 3'd1;
            end else begin
              r_idx <= '0;
              if (r_state == S_INIT) r_init_done <= 1'b1;
              // Back-to-back refresh keeps CS cadence unbroken; otherwise drop to idle.
              if (w_want_refresh) begin
                r_state <= S_REFRESH;
              end else begin
                r_state    <= S_IDLE;
                r_in_frame <= 1'b0;
              end
            end
          end else if (w_last_div) begin
            r_div  <= '0;
            r_slot <= r_slot + 6'd1;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
      endcase
    end
  end

  // Requests arriving while busy collapse into a single pending refresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b1;
    end else if (w_frame_end && w_seq_last) begin
      r_pending <= 1'b0;
    end else if (update && (r_state != S_IDLE)) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_shadow) begin
      r_shadow <= digits_in;
`ifdef STOPWATCH_DP_EN
      r_dp     <= dp_in;
`endif
    end
  end

endmodule

// File: tb/tb_stopwatch_display_spi.sv
// Randomized bench for stopwatch_display_spi: two instances (CLK_DIV 4 and 1) share stimulus,
// each checked against a sequence-level model and an SPI frame decoder.
module tb_stopwatch_display_spi;

  localparam int         CD0  = 4;
  localparam int         CD1  = 1;
  localparam logic [3:0] INT0 = 4'h8;
  localparam logic [3:0] INT1 = 4'h3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        update = 1'b0;
  logic [31:0] digits_in = '0;
  logic [7:0]  dp_in = '0;
  logic [1:0]  busy, init_done, cs_n, sclk, mosi;

  always #5 clk = ~clk;

  stopwatch_display_spi #(.CLK_DIV(CD0), .INTENSITY(INT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in),
`ifdef STOPWATCH_DP_EN
    .dp_in(dp_in),
`endif
    .update(update), .busy(busy[0]), .init_done(init_done[0]),
    .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0])
  );

  stopwatch_display_spi #(.CLK_DIV(CD1), .INTENSITY(INT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in),
`ifdef STOPWATCH_DP_EN
    .dp_in(dp_in),
`endif
    .update(update), .busy(busy[1]), .init_done(init_done[1]),
    .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  function automatic int cdiv(input int i);
    return (i == 0) ? CD0 : CD1;
  endfunction

  // ---------------- sequence-level reference model ----------------
  int          m_rem[2];
  bit          m_boot[2], m_pend[2], m_iseq[2], m_idone[2];
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  task automatic push_f(input int i, input logic [15:0] f);
    if (i == 0) q0.push_back(f);
    else q1.push_back(f);
  endtask

  task automatic push_init(input int i);
    push_f(i, 16'h09FF);
    push_f(i, {8'h0A, 4'h0, (i == 0) ? INT0 : INT1});
    push_f(i, 16'h0B07);
    push_f(i, 16'h0C01);
    push_f(i, 16'h0F00);
  endtask

  task automatic push_refresh(input int i);
    logic [7:0] a;
    logic [3:0] nb;
    logic       dp;
    for (int k = 0; k < 8; k++) begin
      a  = 8'(k + 1);
      nb = digits_in[4*k +: 4];
`ifdef STOPWATCH_DP_EN
      dp = dp_in[k];
`else
      dp = 1'b0;
`endif
      push_f(i, {a, dp, 3'b000, nb});
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rem[i] = 0; m_boot[i] = 1; m_pend[i] = 1; m_iseq[i] = 0; m_idone[i] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(input int i);
    int f;
    f = 34 * cdiv(i);
    if (m_boot[i]) begin
      m_boot[i] = 0; push_init(i); m_rem[i] = 5 * f; m_iseq[i] = 1;
    end else if (m_rem[i] == 0) begin
      m_pend[i] = 0;
      if (update) begin push_refresh(i); m_rem[i] = 8 * f; m_iseq[i] = 0; end
    end else begin
      m_rem[i]--;
      if (m_rem[i] == 0) begin
        if (m_iseq[i]) m_idone[i] = 1;
        m_iseq[i] = 0;
        if (m_pend[i] || update) begin push_refresh(i); m_rem[i] = 8 * f; end
        m_pend[i] = 0;
      end else if (update) begin
        m_pend[i] = 1;
      end
    end
  endtask

  function automatic logic exp_busy(input int i);
    return m_boot[i] || (m_rem[i] != 0);
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // ---------------- SPI decoder / per-cycle monitor ----------------
  bit          p_cs[2], p_sclk[2], p_mosi[2], r_mosi[2];
  int          edges[2], lowlen[2], mstab[2];
  logic [15:0] shreg[2];
  logic [15:0] expf;

  initial begin
    for (int i = 0; i < 2; i++) begin
      p_cs[i] = 1; p_sclk[i] = 0; p_mosi[i] = 0; edges[i] = 0; lowlen[i] = 0; mstab[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check_eq($sformatf("busy%0d", i), busy[i], exp_busy(i));
        check_eq($sformatf("init_done%0d", i), init_done[i], m_idone[i]);
        if (!rst_n) begin
          p_cs[i] = 1; p_sclk[i] = 0; p_mosi[i] = 0; edges[i] = 0; lowlen[i] = 0; mstab[i] = 0;
        end else begin
          mstab[i] = (mosi[i] != p_mosi[i]) ? 1 : mstab[i] + 1;
          if (cs_n[i] == 1'b0) begin
            if (p_cs[i]) begin edges[i] = 0; lowlen[i] = 0; shreg[i] = '0; end
            lowlen[i]++;
            if (sclk[i] && !p_sclk[i]) begin
              edges[i]++;
              shreg[i] = {shreg[i][14:0], mosi[i]};
              r_mosi[i] = mosi[i];
              check_eq($sformatf("mosi_setup%0d", i), (mstab[i] - 1) >= cdiv(i), 1);
            end
            if (!sclk[i] && p_sclk[i])
              check_eq($sformatf("mosi_hold%0d", i), p_mosi[i], r_mosi[i]);
          end else begin
            check_eq($sformatf("sclk_idle%0d", i), sclk[i], 0);
            if (!p_cs[i]) begin
              check_eq($sformatf("edges%0d", i), edges[i], 16);
              check_eq($sformatf("cs_low_len%0d", i), lowlen[i], 33 * cdiv(i));
              check_eq($sformatf("exp_avail%0d", i), (i == 0) ? (q0.size() != 0) : (q1.size() != 0), 1);
              if (i == 0 && q0.size() != 0) begin
                expf = q0.pop_front(); check_eq("frame0", shreg[i], expf);
              end else if (i == 1 && q1.size() != 0) begin
                expf = q1.pop_front(); check_eq("frame1", shreg[i], expf);
              end
            end
          end
          p_cs[i] = cs_n[i]; p_sclk[i] = sclk[i]; p_mosi[i] = mosi[i];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_update();
    @(negedge clk); update = 1'b1;
    @(negedge clk); update = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int c;
    c = 0;
    while ((busy != 2'b00) && c < max_cycles) begin
      @(negedge clk); c++;
    end
    check_eq("idle_reached", busy, 2'b00);
  endtask

  int cnt;

  initial begin
    digits_in = $urandom;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_cs%0d", i), cs_n[i], 1);
      check_eq($sformatf("rst_sclk%0d", i), sclk[i], 0);
      check_eq($sformatf("rst_mosi%0d", i), mosi[i], 0);
      check_eq($sformatf("rst_busy%0d", i), busy[i], 1);
      check_eq($sformatf("rst_idone%0d", i), init_done[i], 0);
    end
    rst_n = 1'b1;
    wait_idle(20000);

    digits_in = 32'h12345678;
    pulse_update();
    cnt = 0;
    while (busy[0] && cnt < 5000) begin
      cnt++; @(negedge clk);
    end
    check_eq("busy_len0", cnt, 1088);
    wait_idle(20000);

    digits_in = $urandom;
    pulse_update();
    repeat (3 * 136 + 20) @(negedge clk);
    digits_in = 32'h99999999;
    for (int p = 0; p < 3; p++) begin
      pulse_update();
      repeat (5) @(negedge clk);
    end
    wait_idle(20000);

`ifdef STOPWATCH_DP_EN
    digits_in = 32'h00000000;
    dp_in = 8'h04;
    pulse_update();
    wait_idle(20000);
`endif

    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) digits_in = $urandom;
      if ($urandom_range(0, 15) == 0) dp_in = 8'($urandom);
      update = ($urandom_range(0, 49) == 0);
    end
    update = 1'b0;
    wait_idle(20000);

    // Abort a refresh in the middle of bit 9 of its first frame.
    digits_in = $urandom;
    pulse_update();
    check_eq("cs_fall0", cs_n[0], 0);
    repeat (74) @(negedge clk);
    check_eq("pre_rst_idone0", init_done[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_cs0", cs_n[0], 1);
    check_eq("abort_sclk0", sclk[0], 0);
    check_eq("abort_mosi0", mosi[0], 0);
    check_eq("abort_idone0", init_done[0], 0);
    check_eq("abort_busy0", busy[0], 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_idle(20000);
    repeat (4) @(negedge clk);
    check_eq("q_empty0", q0.size(), 0);
    check_eq("q_empty1", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
